// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, instruction field positions and the
// fetch FSM state type.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ADDI    = 6'b001000;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StWait  = 2'd1,
        StDrain = 2'd2
    } fetch_state_e;

    function automatic logic [5:0] instr_op(input logic [31:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [5:0] instr_funct(input logic [31:0] instr);
        return instr[FUNCT_MSB:FUNCT_LSB];
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-unit bundle: instruction-memory req/ack port, decode valid/ready port and
// the redirect input. The master side is the fetch unit.
interface inst_fetch_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              id_valid;
    logic              id_ready;
    logic [31:0]       id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic [5:0]        id_op;
    logic [5:0]        id_funct;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, id_op, id_funct,
        input  imem_ack, imem_rdata, id_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_op, id_funct,
        output imem_ack, imem_rdata, id_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_buffer.sv
// Prefetch FIFO of {pc, instr} entries with push, pop, flush and occupancy.
// Storage resets to zero so the head outputs read zero out of reset.
module fetch_buffer #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 32,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [31:0]       i_instr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_pc,
    output logic [31:0]       o_instr,
    output logic [CNT_W-1:0]  o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_pc    [DEPTH];
    logic [31:0]       r_instr [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_push;
    logic w_pop;

    assign o_valid = (r_count != '0);
    assign w_pop   = i_pop & o_valid & ~i_flush;
    // A full buffer can still take a push when the head leaves in the same cycle.
    assign w_push  = i_push & ~i_flush & ((r_count != DEPTH_C) | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc[r_wr_ptr]    <= i_pc;
                r_instr[r_wr_ptr] <= i_instr;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign o_pc    = r_pc[r_rd_ptr];
    assign o_instr = r_instr[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// MIPS instruction fetch unit: owns the PC, keeps at most one imem read in flight
// and feeds decode from a small prefetch buffer.
module inst_fetch
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int unsigned       DEPTH    = 2
) (
    input logic         clk,
    input logic         rst_n,
    inst_fetch_if.master bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] w_pc_inc;

    logic              w_flush;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic [ADDR_W-1:0] w_head_pc;
    logic [31:0]       w_head_instr;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_occ_after;

    // Redirect beats pop beats push: both are voided in a redirect cycle.
    assign w_pop       = w_valid & bus.id_ready & ~bus.redirect;
    assign w_push      = (r_state == StWait) & bus.imem_ack & ~bus.redirect;
    assign w_occ_after = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_pc_inc    = r_fetch_pc + PC_STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StFetch;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_addr     <= w_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_addr_nxt     = r_addr;
        w_flush        = 1'b0;
        unique case (r_state)
            StFetch: begin
                // Flush empties the buffer, so a redirect can issue straight away.
                if (bus.redirect) begin
                    w_flush        = 1'b1;
                    w_fetch_pc_nxt = bus.redirect_pc;
                    w_addr_nxt     = bus.redirect_pc;
                    w_state_nxt    = StWait;
                end else if (w_count < DEPTH_C) begin
                    w_addr_nxt  = r_fetch_pc;
                    w_state_nxt = StWait;
                end
            end
            StWait: begin
                if (bus.imem_ack) begin
                    if (bus.redirect) begin
                        w_flush        = 1'b1;
                        w_fetch_pc_nxt = bus.redirect_pc;
                        w_state_nxt    = StFetch;
                    end else begin
                        // The acked request has retired; only buffered entries count.
                        w_fetch_pc_nxt = w_pc_inc;
                        if (w_occ_after < DEPTH_C) begin
                            w_addr_nxt = w_pc_inc;
                        end else begin
                            w_state_nxt = StFetch;
                        end
                    end
                end else if (bus.redirect) begin
                    w_flush        = 1'b1;
                    w_fetch_pc_nxt = bus.redirect_pc;
                    w_state_nxt    = StDrain;
                end
            end
            StDrain: begin
                if (bus.redirect) begin
                    w_flush        = 1'b1;
                    w_fetch_pc_nxt = bus.redirect_pc;
                end
                if (bus.imem_ack) begin
                    w_state_nxt = StFetch;
                end
            end
            default: begin
                w_state_nxt = StFetch;
            end
        endcase
    end

    fetch_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fetch_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_pc    (r_fetch_pc),
        .i_instr (bus.imem_rdata),
        .o_valid (w_valid),
        .o_pc    (w_head_pc),
        .o_instr (w_head_instr),
        .o_count (w_count)
    );

    assign bus.imem_req  = (r_state != StFetch);
    assign bus.imem_addr = r_addr;
    assign bus.id_valid  = w_valid;
    assign bus.id_pc     = w_head_pc;
    assign bus.id_instr  = w_head_instr;
    assign bus.id_op     = instr_op(w_head_instr);
    assign bus.id_funct  = instr_funct(w_head_instr);

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: memory responder with programmable ack delay,
// scoreboard of accepted fetches checked against what decode receives.
module tb_inst_fetch;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(32)) bus ();
    inst_fetch_if #(.ADDR_W(32)) wbus ();

    inst_fetch #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    inst_fetch #(
        .ADDR_W   (32),
        .RESET_PC (32'hFFFF_FFFC),
        .DEPTH    (2)
    ) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wbus)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] sb[$];
    logic [31:0] exp_fetch;
    logic [31:0] prev_addr;
    logic        prev_req;
    logic        prev_ack;
    logic        draining;
    int          wait_cnt;
    int          ack_delay;
    logic [31:0] wrap_addr[2];
    int          wrap_n = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2001_0005;
            32'h0000_0004: return 32'h0022_1820;
            default:       return {a[15:0] ^ 16'h5A5A, a[15:0]};
        endcase
    endfunction

    // Called at posedge+1; drives this cycle's ack, checks at negedge, returns at posedge+1.
    task automatic step();
        logic        req;
        logic        ack;
        logic        rdr;
        logic [31:0] addr;
        logic [63:0] e;
        if (bus.imem_req && wait_cnt >= ack_delay) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem_word(bus.imem_addr);
        end else begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = 32'hDEAD_BEEF;
        end
        wbus.imem_ack   = wbus.imem_req;
        wbus.imem_rdata = 32'h0;
        @(negedge clk);
        req  = bus.imem_req;
        ack  = bus.imem_ack;
        rdr  = bus.redirect;
        addr = bus.imem_addr;
        if (req) begin
            if (prev_req && !prev_ack) check_eq("addr_stable", addr, prev_addr);
            else check_eq("req_addr", addr, exp_fetch);
        end
        if (bus.id_valid && bus.id_ready && !rdr) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check_eq("id_pc", bus.id_pc, e[63:32]);
                check_eq("id_instr", bus.id_instr, e[31:0]);
                check_eq("id_op", 32'(bus.id_op), 32'(e[31:26]));
                check_eq("id_funct", 32'(bus.id_funct), 32'(e[5:0]));
            end
        end
        if (ack) begin
            if (!rdr && !draining) begin
                sb.push_back({addr, bus.imem_rdata});
                exp_fetch = addr + 32'd4;
            end
            draining = 1'b0;
            wait_cnt = 0;
        end else if (req) begin
            wait_cnt++;
        end
        if (rdr) begin
            exp_fetch = bus.redirect_pc;
            if (req && !ack) draining = 1'b1;
        end
        prev_req  = req;
        prev_ack  = ack;
        prev_addr = addr;
        if (wbus.imem_req && wrap_n < 2) begin
            wrap_addr[wrap_n] = wbus.imem_addr;
            wrap_n++;
        end
        @(posedge clk);
        #1;
    endtask

    // Holds reset across an edge, checks reset outputs, then releases at posedge+1.
    task automatic reset_end();
        @(posedge clk);
        #1;
        check_eq("rst_req", 32'(bus.imem_req), 32'd0);
        check_eq("rst_valid", 32'(bus.id_valid), 32'd0);
        check_eq("rst_addr", bus.imem_addr, 32'h0);
        sb.delete();
        exp_fetch    = 32'h0;
        prev_req     = 1'b0;
        prev_ack     = 1'b0;
        prev_addr    = 32'h0;
        draining     = 1'b0;
        wait_cnt     = 0;
        bus.imem_ack = 1'b0;
        bus.redirect = 1'b0;
        rst_n        = 1'b1;
        check_eq("rel_req_low", 32'(bus.imem_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic found;
        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = 32'h0;
        bus.id_ready     = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = 32'h0;
        wbus.imem_ack    = 1'b0;
        wbus.imem_rdata  = 32'h0;
        wbus.id_ready    = 1'b1;
        wbus.redirect    = 1'b0;
        wbus.redirect_pc = 32'h0;
        ack_delay        = 0;
        rst_n            = 1'b0;
        reset_end();

        // Streaming with zero-wait memory
        bus.id_ready = 1'b1;
        ack_delay    = 0;
        step();
        check_eq("first_req", 32'(bus.imem_req), 32'd1);
        check_eq("first_addr", bus.imem_addr, 32'h0);
        step();
        check_eq("s0_valid", 32'(bus.id_valid), 32'd1);
        check_eq("s0_pc", bus.id_pc, 32'h0);
        check_eq("s0_op", 32'(bus.id_op), 32'(OP_ADDI));
        step();
        check_eq("s1_pc", bus.id_pc, 32'h4);
        check_eq("s1_op", 32'(bus.id_op), 32'(OP_SPECIAL));
        check_eq("s1_funct", 32'(bus.id_funct), 32'h20);
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("stream_req", 32'(bus.imem_req), 32'd1);
            check_eq("stream_valid", 32'(bus.id_valid), 32'd1);
        end

        // Asynchronous reset with a request outstanding and an entry buffered
        rst_n = 1'b0;
        reset_end();
        bus.id_ready = 1'b0;
        ack_delay    = 0;
        step();
        step();
        ack_delay = 5;
        step();
        check_eq("pre_rst_req", 32'(bus.imem_req), 32'd1);
        check_eq("pre_rst_valid", 32'(bus.id_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_req", 32'(bus.imem_req), 32'd0);
        check_eq("arst_valid", 32'(bus.id_valid), 32'd0);
        check_eq("arst_addr", bus.imem_addr, 32'h0);
        check_eq("arst_pc", bus.id_pc, 32'h0);
        check_eq("arst_instr", bus.id_instr, 32'h0);
        check_eq("arst_op", 32'(bus.id_op), 32'd0);
        check_eq("arst_funct", 32'(bus.id_funct), 32'd0);
        reset_end();

        // Backpressure: decode stalled from the start
        ack_delay = 0;
        for (int i = 0; i < 5; i++) step();
        check_eq("bp_req_low", 32'(bus.imem_req), 32'd0);
        check_eq("bp_valid", 32'(bus.id_valid), 32'd1);
        check_eq("bp_head_pc", bus.id_pc, 32'h0);
        check_eq("bp_entries", 32'(sb.size()), 32'd2);
        bus.id_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (bus.imem_req) found = 1'b1;
        end
        check_eq("bp_resume_seen", 32'(found), 32'd1);
        check_eq("bp_resume_addr", bus.imem_addr, 32'h8);
        check_eq("bp_drained", 32'(sb.size()), 32'd0);

        // Redirect while a slow request is outstanding
        rst_n = 1'b0;
        reset_end();
        bus.id_ready = 1'b1;
        ack_delay    = 3;
        step();
        check_eq("rd_req", 32'(bus.imem_req), 32'd1);
        check_eq("rd_addr", bus.imem_addr, 32'h0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        step();
        bus.redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            check_eq("rd_valid_low", 32'(bus.id_valid), 32'd0);
            step();
            if (bus.imem_req && !prev_req) found = 1'b1;
        end
        check_eq("rd_new_req_seen", 32'(found), 32'd1);
        check_eq("rd_new_addr", bus.imem_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (bus.id_valid) found = 1'b1;
            else step();
        end
        check_eq("rd_data_seen", 32'(found), 32'd1);
        check_eq("rd_first_pc", bus.id_pc, 32'h100);
        for (int i = 0; i < 4; i++) step();

        // PC wrap on the second instance
        check_eq("wrap_n", 32'(wrap_n), 32'd2);
        check_eq("wrap_addr0", wrap_addr[0], 32'hFFFF_FFFC);
        check_eq("wrap_addr1", wrap_addr[1], 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
